pwm_breathe_multi: RTL and testbench

//  Multi-channel PWM LED driver with a per-channel mode: off, static duty or sine "breathe".

---
 rtl/pwm_breathe_pkg.sv | 30 +++
 rtl/pwm_breathe_multi_sine_lut.sv | 29 ++
 rtl/pwm_breathe_multi.sv | 110 +++++++++++
 tb/tb_pwm_breathe_multi.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_breathe_pkg.sv
// Shared definitions for the multi-channel breathing PWM driver: channel mode
// encodings and the constant function that fills the breathe (raised-cosine) table.
package pwm_breathe_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_STATIC  = 2'b01,
        MODE_BREATHE = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    // Integer cubic 3t^2-2t^3 stands in for 0.5*(1-cos(pi*t)) so the table elaborates
    // without real arithmetic; 0 at entry 0, full scale at depth/2, mirror-symmetric.
    function automatic int sine_val(input int i, input int depth, input int width);
        longint h;
        longint d;
        longint peak;
        longint num;
        longint den;
        h = longint'(depth / 2);
        d = longint'((i < depth - i) ? i : depth - i);
        if (d > h) d = h;
        if (h == 0) return 0;
        peak = (longint'(1) <<< width) - 1;
        den  = h * h * h;
        num  = peak * (3 * d * d * h - 2 * d * d * d);
        return int'((num + den / 2) / den);
    endfunction

endpackage

// File: rtl/pwm_breathe_multi_sine_lut.sv
// Combinational breathe ROM: one table entry per index, out-of-range addresses read 0.
module sine_lut
    import pwm_breathe_pkg::*;
#(
    parameter int LUT_DEPTH = 100,
    parameter int PWM_W     = 6,
    parameter int IDX_W     = $clog2(LUT_DEPTH)
) (
    input  logic [IDX_W-1:0] addr_i,
    output logic [PWM_W-1:0] duty_o
);

    localparam logic [IDX_W:0] DEPTH_EXT = (IDX_W + 1)'(LUT_DEPTH);

    logic [PWM_W-1:0] rom [LUT_DEPTH];

    generate
        for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_rom
            localparam logic [PWM_W-1:0] ENTRY = PWM_W'(sine_val(gi, LUT_DEPTH, PWM_W));
            assign rom[gi] = ENTRY;
        end
    endgenerate

    always_comb begin
        duty_o = '0;
        if ({1'b0, addr_i} < DEPTH_EXT) duty_o = rom[addr_i];
    end

endmodule

// File: rtl/pwm_breathe_multi.sv
// NCH-channel PWM LED driver with per-channel off/static/breathe modes; duties are
// latched only at period boundaries so each PWM period is glitch-free.
module pwm_breathe_multi
    import pwm_breathe_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int PWM_W     = 6,
    parameter int LUT_DEPTH = 100,
    parameter int RATE_MULT = 10,
    parameter int IDX_W     = $clog2(LUT_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [2*NCH-1:0]     mode,
    input  logic [PWM_W*NCH-1:0] level,
    input  logic [PWM_W-1:0]     rate,
    output logic [NCH-1:0]       pwm_out,
    output logic                 per_end,
    output logic [IDX_W-1:0]     idx
);

    localparam int TICK_W = PWM_W + $clog2(RATE_MULT) + 1;
    localparam logic [PWM_W-1:0] CNT_MAX   = '1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(LUT_DEPTH - 1);
    localparam logic [IDX_W:0]   DEPTH_EXT = (IDX_W + 1)'(LUT_DEPTH);

    logic [PWM_W-1:0]  cnt_q;
    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_limit;
    logic [IDX_W-1:0]  idx_q;
    logic [NCH-1:0]    pwm_q;
    logic              per_end_q;
    logic              period_last;
    logic [NCH-1:0]    cmp;

    assign period_last = (cnt_q == CNT_MAX);
    assign tick_limit  = TICK_W'(RATE_MULT) * TICK_W'(rate);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            localparam logic [IDX_W:0] OFFSET = (IDX_W + 1)'((gi * LUT_DEPTH) / NCH);

            logic [IDX_W:0]   addr_sum;
            logic [IDX_W-1:0] addr;
            logic [PWM_W-1:0] sine;
            logic [PWM_W-1:0] duty_d;
            logic [PWM_W-1:0] duty_q;

            // Both operands are below LUT_DEPTH, so one subtract completes the wrap.
            assign addr_sum = {1'b0, idx_q} + OFFSET;
            assign addr     = (addr_sum >= DEPTH_EXT) ? IDX_W'(addr_sum - DEPTH_EXT)
                                                      : addr_sum[IDX_W-1:0];

            sine_lut #(
                .LUT_DEPTH(LUT_DEPTH),
                .PWM_W    (PWM_W),
                .IDX_W    (IDX_W)
            ) u_lut (
                .addr_i(addr),
                .duty_o(sine)
            );

            always_comb begin
                duty_d = '0;
                case (mode[2*gi +: 2])
                    MODE_STATIC:  duty_d = level[PWM_W*gi +: PWM_W];
                    MODE_BREATHE: duty_d = sine;
                    default:      duty_d = '0;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    duty_q <= '0;
                end else if (period_last) begin
                    duty_q <= duty_d;
                end
            end

            assign cmp[gi] = (duty_q > cnt_q);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            tick_q    <= '0;
            idx_q     <= '0;
            pwm_q     <= '0;
            per_end_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_q + 1'b1;
            per_end_q <= period_last;
            pwm_q     <= {NCH{en}} & cmp;
            // >= rather than == so lowering rate below the running tick wraps at once.
            if (tick_q >= tick_limit) begin
                tick_q <= '0;
                idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                tick_q <= tick_q + 1'b1;
            end
        end
    end

    assign pwm_out = pwm_q;
    assign per_end = per_end_q;
    assign idx     = idx_q;

endmodule

// File: tb/tb_pwm_breathe_multi.sv
// Directed bench for pwm_breathe_multi (NCH=4, PWM_W=6, LUT_DEPTH=100, RATE_MULT=10).
module tb_pwm_breathe_multi;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  mode;
    logic [23:0] level;
    logic [5:0]  rate;
    logic [3:0]  pwm_out;
    logic        per_end;
    logic [6:0]  idx;

    int n_checks = 0;
    int n_fails  = 0;
    int hi [4];
    int first_bits;

    pwm_breathe_multi #(
        .NCH      (4),
        .PWM_W    (6),
        .LUT_DEPTH(100),
        .RATE_MULT(10)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .level  (level),
        .rate   (rate),
        .pwm_out(pwm_out),
        .per_end(per_end),
        .idx    (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the negedge just before the first un-reset posedge.
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic sync_per_end(input string tag);
        int n;
        n = 0;
        while (per_end !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(per_end), 1);
    endtask

    // Called at a per_end negedge: accumulates one full period of pwm_out, ending on the next per_end.
    task automatic measure();
        for (int k = 0; k < 4; k++) hi[k] = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i == 0) first_bits = int'(pwm_out);
            for (int k = 0; k < 4; k++) hi[k] += int'(pwm_out[k]);
        end
        $display("period: ch0=%0d ch1=%0d ch2=%0d ch3=%0d per_end=%0b", hi[0], hi[1], hi[2], hi[3], per_end);
    endtask

    initial begin
        int n;
        int step_at;
        int i0;
        rst   = 1'b1;
        en    = 1'b1;
        mode  = 8'b0000_0001;
        level = 24'd16;
        rate  = 6'd63;

        // Reset state and static duty 16 on channel 0
        do_reset();
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_per_end", int'(per_end), 0);
        check("rst_idx", int'(idx), 0);
        sync_per_end("t1_sync");
        measure();
        check("t1_ch0_hi", hi[0], 16);
        check("t1_ch0_first", first_bits & 1, 1);
        check("t1_ch1_hi", hi[1], 0);
        check("t1_ch3_hi", hi[3], 0);
        check("t1_per_end", int'(per_end), 1);

        // Level change mid-period is deferred to the next period
        hi[0] = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            hi[0] += int'(pwm_out[0]);
            if (i == 20) level[5:0] = 6'd48;
        end
        $display("period: ch0=%0d (level changed mid-period)", hi[0]);
        check("t2_cur_period", hi[0], 16);
        measure();
        check("t2_next_period", hi[0], 48);

        // Boundaries: duty 0, duty 63, reserved mode
        level[5:0] = 6'd0;
        measure();
        measure();
        check("t5_duty0", hi[0], 0);
        level[5:0] = 6'd63;
        measure();
        measure();
        check("t5_duty63", hi[0], 63);
        mode[1:0]  = 2'b11;
        level[5:0] = 6'd40;
        measure();
        measure();
        check("t5_mode11", hi[0], 0);

        // en dropped mid-period: output low next cycle, counter keeps running
        mode[1:0]  = 2'b01;
        level[5:0] = 6'd48;
        measure();
        hi[0] = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            hi[0] += int'(pwm_out[0]);
            if (i == 10) begin
                check("t5_before_en0", int'(pwm_out[0]), 1);
                en = 1'b0;
            end
            if (i == 11) check("t5_after_en0", int'(pwm_out[0]), 0);
        end
        $display("period: ch0=%0d (en dropped at sample 10)", hi[0]);
        check("t5_en0_hi", hi[0], 11);
        check("t5_en0_per_end", int'(per_end), 1);
        en = 1'b1;

        // Phase stagger: all breathe, idx held at 0 across the first period end
        mode = 8'b1010_1010;
        rate = 6'd63;
        do_reset();
        sync_per_end("t4_sync");
        measure();
        check("t4_ch0", hi[0], 0);
        check("t4_ch1", hi[1], 32);
        check("t4_ch2", hi[2], 63);
        check("t4_ch3", hi[3], 32);
        check("t4_idx", int'(idx), 0);

        // Breathe timer: rate=1 steps every 11 cycles, wraps at 1100
        rate = 6'd1;
        do_reset();
        step_at = 0;
        for (int c = 1; c <= 1100; c++) begin
            @(negedge clk);
            if (step_at == 0 && idx == 7'd1) step_at = c;
            if (c == 1089) check("t3_idx99", int'(idx), 99);
            if (c == 1100) check("t3_wrap", int'(idx), 0);
        end
        $display("rate=1: first idx step after %0d cycles", step_at);
        check("t3_first_step", step_at, 11);
        rate = 6'd0;
        i0 = int'(idx);
        repeat (5) @(negedge clk);
        $display("rate=0: idx %0d -> %0d in 5 cycles", i0, idx);
        check("t3_rate0", int'(idx), (i0 + 5) % 100);

        // Reset mid-operation with pwm_out high and idx=37
        mode  = 8'b0000_0001;
        level = 24'd63;
        en    = 1'b1;
        do_reset();
        n = 0;
        while (!(idx == 7'd37 && pwm_out[0] == 1'b1 && n > 64) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("t6_reached", int'(idx), 37);
        rst = 1'b1;
        @(negedge clk);
        check("t6_pwm", int'(pwm_out), 0);
        check("t6_idx", int'(idx), 0);
        check("t6_per_end", int'(per_end), 0);
        rst = 1'b0;
        n = 0;
        while (per_end !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        $display("after reset release: per_end after %0d cycles", n);
        check("t6_first_per_end", n, 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
